mp_add_scheduler: RTL and testbench

Word-serial multi-precision add scheduler that shares one external BITWIDTH-bit combinational prefix adder between NUM_REQ requesters. Each requester streams a multi-word add, least-significant word first. The block arbitrates round-robin at transaction granularity, chains the carry between words in a register, and returns registered per-word sums with a final carry-out. It sits between the requesting units and the shared adder instance.

---
 rtl/mp_add_scheduler_pkg.sv | 18 +
 rtl/mp_add_scheduler_rr_arbiter.sv | 47 ++++
 rtl/mp_add_scheduler.sv | 138 +++++++++++++
 tb/tb_mp_add_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_scheduler_pkg.sv
// Shared types for the multi-precision add scheduler: FSM state encoding and
// the helper that sizes requester id fields.
package mp_add_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int NUM_REQ_DFLT = 2;
  localparam int ID_W         = $clog2(NUM_REQ_DFLT);

  // Keeps id fields at least one bit wide even for degenerate requester counts.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mp_add_scheduler_rr_arbiter.sv
// Round-robin pick: first valid requester at or after ptr_i, wrapping.
// Produces both one-hot and encoded grants.
module rr_arbiter
  import mp_add_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [IDW-1:0]     grant_idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] rot_s;
  int                   sel_s;

  // Rotating the doubled request vector turns the wrap-around search into a plain
  // lowest-set-bit scan.
  always_comb begin
    rot_s       = {valid_i, valid_i} >> ptr_i;
    any_o       = 1'b0;
    sel_s       = 0;
    grant_idx_o = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!any_o && rot_s[j]) begin
        any_o = 1'b1;
        sel_s = int'(ptr_i) + j;
        if (sel_s >= NUM_REQ) begin
          sel_s = sel_s - NUM_REQ;
        end else begin
          sel_s = sel_s;
        end
        grant_idx_o = IDW'(sel_s);
      end else begin
        any_o = any_o;
      end
    end
    if (any_o) begin
      grant_oh_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_o;
    end else begin
      grant_oh_o = '0;
    end
  end

endmodule

// File: rtl/mp_add_scheduler.sv
// Word-serial multi-precision add scheduler sharing one external adder between
// NUM_REQ requesters, with transaction-level round-robin and a chained carry.
module mp_add_scheduler
  import mp_add_pkg::*;
#(
  parameter  int BITWIDTH = 8,
  parameter  int NUM_REQ  = 2,
  localparam int IDW      = id_width(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*BITWIDTH-1:0] req_a,
  input  logic [NUM_REQ*BITWIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]          req_carry_in,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [BITWIDTH-1:0]         add_a,
  output logic [BITWIDTH-1:0]         add_b,
  output logic                        add_cin,
  input  logic [BITWIDTH-1:0]         add_sum,
  input  logic                        add_cout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BITWIDTH-1:0]         out_sum,
  output logic                        out_last,
  output logic                        out_carry,
  output logic [IDW-1:0]              out_id
);

  state_e               state_q;
  logic [IDW-1:0]       grant_q;
  logic [NUM_REQ-1:0]   grant_oh_q;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       rr_ptr_d;
  logic                 first_q;
  logic                 carry_q;
  logic                 out_valid_q;
  logic [BITWIDTH-1:0]  out_sum_q;
  logic                 out_last_q;
  logic                 out_carry_q;
  logic [IDW-1:0]       out_id_q;

  logic [NUM_REQ-1:0]   arb_oh_s;
  logic [IDW-1:0]       arb_idx_s;
  logic                 arb_any_s;
  logic                 space_s;
  logic                 accept_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .valid_i     (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (arb_oh_s),
    .grant_idx_o (arb_idx_s),
    .any_o       (arb_any_s)
  );

  // A word may enter only when the output register is empty or draining this cycle.
  assign space_s   = !out_valid_q || out_ready;
  assign accept_s  = (state_q == BUSY) && req_valid[grant_q] && space_s;
  assign req_ready = grant_oh_q & {NUM_REQ{(state_q == BUSY) && space_s}};

  assign add_a   = accept_s ? req_a[grant_q*BITWIDTH +: BITWIDTH] : '0;
  assign add_b   = accept_s ? req_b[grant_q*BITWIDTH +: BITWIDTH] : '0;
  assign add_cin = accept_s && (first_q ? req_carry_in[grant_q] : carry_q);

  assign rr_ptr_d = (grant_q == IDW'(NUM_REQ-1)) ? '0 : grant_q + IDW'(1);

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_carry = out_carry_q;
  assign out_id    = out_id_q;

  // Scheduler FSM, carry chain and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= '0;
      first_q     <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
      out_id_q    <= '0;
    end else begin
      if (accept_s) begin
        out_valid_q <= 1'b1;
        out_sum_q   <= add_sum;
        out_last_q  <= req_last[grant_q];
        out_carry_q <= add_cout;
        out_id_q    <= grant_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= out_valid_q;
      end
      case (state_q)
        IDLE: begin
          if (arb_any_s) begin
            grant_q    <= arb_idx_s;
            grant_oh_q <= arb_oh_s;
            first_q    <= 1'b1;
            state_q    <= BUSY;
          end else begin
            state_q    <= IDLE;
          end
        end
        BUSY: begin
          if (accept_s) begin
            carry_q <= add_cout;
            first_q <= 1'b0;
            if (req_last[grant_q]) begin
              state_q    <= IDLE;
              grant_oh_q <= '0;
              rr_ptr_q   <= rr_ptr_d;
            end else begin
              state_q    <= BUSY;
            end
          end else begin
            state_q <= BUSY;
          end
        end
        default: begin
          state_q    <= IDLE;
          grant_oh_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_scheduler.sv
// Self-checking bench for mp_add_scheduler: directed scenarios plus randomized
// multi-word transactions scored against whole-number arithmetic.
module tb_mp_add_scheduler;

  localparam int W  = 8;
  localparam int NR = 2;

  typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; logic cin; logic last; } word_t;
  typedef struct packed { logic [W-1:0] sum; logic last; logic carry; } res_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_ready, req_carry_in, req_last;
  logic [NR*W-1:0] req_a, req_b;
  logic [W-1:0]    add_a, add_b, add_sum;
  logic            add_cin, add_cout;
  logic            out_valid, out_ready, out_last, out_carry;
  logic [W-1:0]    out_sum;
  logic [0:0]      out_id;

  int checks = 0;
  int errors = 0;

  word_t wq[NR][$];
  res_t  eq[NR][$];

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared external adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  mp_add_scheduler #(.BITWIDTH(W), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_carry_in(req_carry_in), .req_last(req_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last),
    .out_carry(out_carry), .out_id(out_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_a = '0; req_b = '0; req_carry_in = '0; req_last = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive_word(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic last);
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_carry_in[i] = cin;
    req_last[i] = last;
  endtask

  // Drives one word and returns #1 after the edge that accepted it.
  task automatic send_word(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic last);
    int n;
    drive_word(i, a, b, cin, last);
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("hs_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] sum, input logic last,
                           input logic [0:0] id);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_sum"}, {24'd0, out_sum}, {24'd0, sum});
    check_eq({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
    check_eq({tag, "_id"}, {31'd0, out_id}, {31'd0, id});
  endtask

  task automatic gen_txns(input int n_txn);
    for (int i = 0; i < NR; i++) begin
      for (int t = 0; t < n_txn; t++) begin
        int len;
        logic [39:0] av, bv;
        logic [40:0] tot;
        logic cin;
        len = $urandom_range(1, 4);
        av = '0; bv = '0;
        for (int w = 0; w < len; w++) begin
          av[w*W +: W] = 8'($urandom);
          bv[w*W +: W] = 8'($urandom);
        end
        cin = 1'($urandom);
        tot = {1'b0, av} + {1'b0, bv} + {40'd0, cin};
        for (int w = 0; w < len; w++) begin
          wq[i].push_back('{a: av[w*W +: W], b: bv[w*W +: W],
                            cin: (w == 0) ? cin : 1'($urandom), last: (w == len-1)});
          eq[i].push_back('{sum: tot[w*W +: W], last: (w == len-1), carry: tot[len*W]});
        end
      end
    end
  endtask

  initial begin
    int cyc, prev_cyc, nres, n;
    int ids[4];
    logic lock_ok;
    logic [W-1:0] held_sum;
    logic [NR-1:0] hs;
    logic in_txn;
    logic [0:0] owner;
    res_t e;

    rst = 1'b0;
    apply_reset();
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_ready", {30'd0, req_ready}, 32'd0);
    check_eq("rst_out", {22'd0, out_sum, out_last, out_carry}, 32'd0);

    // Single word: result two edges after req_valid rises.
    drive_word(0, 8'h0F, 8'h01, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_eq("sw_valid_early", {31'd0, out_valid}, 32'd0);
    check_eq("sw_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    check_out("sw", 8'h10, 1'b1, 1'b0);
    check_eq("sw_carry", {31'd0, out_carry}, 32'd0);

    // Carry chain on requester 1.
    apply_reset();
    send_word(1, 8'hFF, 8'h01, 1'b0, 1'b0);
    check_out("cc0", 8'h00, 1'b0, 1'b1);
    send_word(1, 8'h00, 8'h00, 1'b1, 1'b1);
    check_out("cc1", 8'h01, 1'b1, 1'b1);
    check_eq("cc1_carry", {31'd0, out_carry}, 32'd0);
    send_word(1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    check_out("cc2", 8'hFF, 1'b1, 1'b1);
    check_eq("cc2_carry", {31'd0, out_carry}, 32'd1);

    // Round-robin with both requesters always valid, single-word transactions.
    apply_reset();
    drive_word(0, 8'h01, 8'h02, 1'b0, 1'b1);
    drive_word(1, 8'h10, 8'h20, 1'b0, 1'b1);
    nres = 0; prev_cyc = 0;
    for (cyc = 0; cyc < 30 && nres < 4; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        ids[nres] = int'(out_id);
        if (nres > 0) check_eq("rr_gap", cyc - prev_cyc, 32'd2);
        prev_cyc = cyc;
        nres++;
      end
    end
    check_eq("rr_count", nres, 32'd4);
    check_eq("rr_seq", {ids[0][7:0], ids[1][7:0], ids[2][7:0], ids[3][7:0]}, 32'h00010001);

    // Grant lock: requester 0 three-word transaction, requester 1 valid throughout.
    apply_reset();
    drive_word(1, 8'h33, 8'h44, 1'b0, 1'b1);
    lock_ok = 1'b1;
    for (int w = 0; w < 3; w++) begin
      drive_word(0, 8'(w + 1), 8'h00, 1'b0, (w == 2));
      n = 0;
      @(negedge clk);
      while (!req_ready[0] && n < 20) begin
        if (req_ready[1]) lock_ok = 1'b0;
        @(negedge clk);
        n++;
      end
      if (req_ready[1]) lock_ok = 1'b0;
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    check_eq("lock_r1_ready", {31'd0, lock_ok}, 32'd1);
    check_out("lock_w2", 8'h03, 1'b1, 1'b0);
    n = 0;
    while (!(out_valid && out_id == 1'b1) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid[1] = 1'b0;
    check_out("lock_r1", 8'h77, 1'b1, 1'b1);

    // Backpressure: result held three cycles, then accept and drain together.
    apply_reset();
    out_ready = 1'b0;
    send_word(0, 8'h11, 8'h22, 1'b0, 1'b0);
    held_sum = out_sum;
    drive_word(0, 8'h05, 8'h06, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_out("bp_hold", 8'h33, 1'b0, 1'b0);
      check_eq("bp_ready", {30'd0, req_ready}, 32'd0);
    end
    check_eq("bp_stable", {24'd0, out_sum}, {24'd0, held_sum});
    out_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    check_out("bp_rel", 8'h0B, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_eq("bp_nodup", {31'd0, out_valid}, 32'd0);

    // Reset mid-transaction, leaving a stale carry of 1.
    apply_reset();
    send_word(0, 8'hFF, 8'h00, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mr_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mr_out", {21'd0, out_sum, out_last, out_carry, out_id}, 32'd0);
    check_eq("mr_ready", {30'd0, req_ready}, 32'd0);
    send_word(0, 8'h01, 8'h01, 1'b0, 1'b1);
    check_out("mr_new", 8'h02, 1'b1, 1'b0);

    // Randomized transactions from both requesters with random stalls.
    apply_reset();
    gen_txns(12);
    in_txn = 1'b0; owner = 1'b0;
    for (cyc = 0; cyc < 5000; cyc++) begin
      if (wq[0].size() == 0 && wq[1].size() == 0 && eq[0].size() == 0 && eq[1].size() == 0)
        break;
      for (int i = 0; i < NR; i++) begin
        if (wq[i].size() > 0) begin
          drive_word(i, wq[i][0].a, wq[i][0].b, wq[i][0].cin, wq[i][0].last);
          req_valid[i] = ($urandom_range(0, 3) != 0);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hs = req_valid & req_ready;
      if (out_valid && out_ready) begin
        if (in_txn) check_eq("rand_lock", {31'd0, out_id}, {31'd0, owner});
        if (eq[out_id].size() == 0) begin
          check_eq("rand_extra", 32'd1, 32'd0);
        end else begin
          e = eq[out_id].pop_front();
          check_eq("rand_sum", {24'd0, out_sum}, {24'd0, e.sum});
          check_eq("rand_last", {31'd0, out_last}, {31'd0, e.last});
          if (e.last) check_eq("rand_carry", {31'd0, out_carry}, {31'd0, e.carry});
        end
        owner = out_id;
        in_txn = !out_last;
      end
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) void'(wq[i].pop_front());
      end
      @(posedge clk); #1;
    end
    check_eq("rand_drain", wq[0].size() + wq[1].size() + eq[0].size() + eq[1].size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
